// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the shared 32-bit MIPS multicycle datapath.
// It sequences fetch, decode, execute, memory and writeback, and it drives the
// extender mode. The memory handshake is req/ready, with a timeout that traps.
// Optional retire counter: define MIPS_CTRL_RETIRE_CNT_EN to add the
// retired[31:0] output.
// All outputs are combinational from the state, opcode/funct and the handshake
// inputs. They are gated to 0 while rst_n is low, so mem_req drops
// asynchronously on reset.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       target_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_sel,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
`ifdef MIPS_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cause_to;
  logic             w_cause_to;
  logic             w_funct_ok;
  logic [2:0]       w_funct_op;
  logic             w_timeout;

  // Map funct to an ALU operation and flag unsupported R-type functions.
  always_comb begin
    w_funct_ok = 1'b1;
    w_funct_op = ALU_ADD;
    case (funct)
      6'h20:   w_funct_op = ALU_ADD;
      6'h22:   w_funct_op = ALU_SUB;
      6'h24:   w_funct_op = ALU_AND;
      6'h25:   w_funct_op = ALU_OR;
      6'h2A:   w_funct_op = ALU_SLT;
      default: w_funct_ok = 1'b0;
    endcase
  end

  // Bus timeout: the wait count reached the limit and ready is still low.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT)) && !mem_ready;

  // Next-state and datapath control decode.
  always_comb begin
    w_next       = r_state;
    w_cause_to   = r_cause_to;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    target_we    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = ALU_ADD;
    ext_sel      = (opcode == OP_ANDI) || (opcode == OP_ORI);
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_op   = 1'b0;
    bus_err      = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_TRAP;
          w_cause_to = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        target_we = 1'b1;
        case (opcode)
          OP_RTYPE: w_next = w_funct_ok ? S_EXEC_R : S_TRAP;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:   w_next = S_BRANCH;
          OP_J:     w_next = S_JUMP;
          default:  w_next = S_TRAP;
        endcase
        w_cause_to = 1'b0;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = w_funct_op;
        w_next    = S_WB_R;
      end
      S_WB_R: begin
        alu_src_a = 1'b1;
        alu_op    = w_funct_op;
        reg_we    = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ANDI)     alu_op = ALU_AND;
        else if (opcode == OP_ORI) alu_op = ALU_OR;
        w_next = S_WB_I;
      end
      S_WB_I: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (r_state == S_MEM_WR);
        if (mem_ready) begin
          w_next = (r_state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
        end else if (w_timeout) begin
          w_next     = S_TRAP;
          w_cause_to = 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_we     = zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = !r_cause_to;
        bus_err    = r_cause_to;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      target_we    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = ALU_ADD;
      ext_sel      = 1'b0;
      reg_we       = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      illegal_op   = 1'b0;
      bus_err      = 1'b0;
    end
  end

  assign state = rst_n ? r_state : 4'd0;

  // State register and latched trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_cause_to <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cause_to <= w_cause_to;
    end
  end

  // Wait counter: cleared on every state change, counts stalled request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (mem_req && !mem_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retired;

  // Count instructions that complete normally; a trap exit never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= 32'd0;
    end else if ((w_next == S_FETCH) &&
                 (r_state inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP})) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl, built with TIMEOUT = 4.
// Each step pushes the expected state and outputs into a queue when the
// inputs are driven. The entry is popped and compared at the following
// falling edge.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, target_we, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic        ext_sel, reg_we, reg_dst, mem_to_reg, illegal_op, bus_err;
  logic [3:0]  state;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] outs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic to_cause = 1'b0;
  logic [19:0] w_outs;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .target_we(target_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_sel(ext_sel), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .bus_err(bus_err),
    .state(state)
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  assign w_outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, target_we,
                   alu_src_a, alu_src_b, alu_op, ext_sel, reg_we, reg_dst,
                   mem_to_reg, illegal_op, bus_err};

  // Reference output table for one state under the current inputs.
  function automatic logic [19:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z,
                                        input logic rdy, input logic to);
    logic mreq, mwe, masel, irwe, pcwe, tgt, asa, ext, rwe, rdst, m2r, ill, be;
    logic [1:0] psrc, asb;
    logic [2:0] aop, fop;
    {mreq, mwe, masel, irwe, pcwe, tgt, asa, rwe, rdst, m2r, ill, be} = '0;
    psrc = 2'b00; asb = 2'b00; aop = 3'b000;
    ext  = (op == 6'h0C) || (op == 6'h0D);
    case (fn)
      6'h22:   fop = 3'b001;
      6'h24:   fop = 3'b010;
      6'h25:   fop = 3'b011;
      6'h2A:   fop = 3'b100;
      default: fop = 3'b000;
    endcase
    case (st)
      4'd0:  begin mreq = 1'b1; asb = 2'b01; irwe = rdy; pcwe = rdy; end
      4'd1:  begin asb = 2'b11; tgt = 1'b1; end
      4'd2:  begin asa = 1'b1; aop = fop; end
      4'd3:  begin
               asa = 1'b1; asb = 2'b10;
               aop = (op == 6'h0C) ? 3'b010 : (op == 6'h0D) ? 3'b011 : 3'b000;
             end
      4'd4:  begin asa = 1'b1; asb = 2'b10; end
      4'd5:  begin mreq = 1'b1; masel = 1'b1; end
      4'd6:  begin mreq = 1'b1; masel = 1'b1; mwe = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = fop; rwe = 1'b1; rdst = 1'b1; end
      4'd8:  begin rwe = 1'b1; end
      4'd9:  begin rwe = 1'b1; m2r = 1'b1; end
      4'd10: begin asa = 1'b1; aop = 3'b001; psrc = 2'b01; pcwe = z; end
      4'd11: begin psrc = 2'b10; pcwe = 1'b1; end
      4'd12: begin ill = !to; be = to; end
      default: ;
    endcase
    return {mreq, mwe, masel, irwe, pcwe, psrc, tgt, asa, asb, aop, ext, rwe, rdst,
            m2r, ill, be};
  endfunction

  task automatic check_pop(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    checks++;
    assert (state === e.st) else begin
      errors++;
      $error("FAIL %s.state: got %0d expected %0d", tag, state, e.st);
    end
    checks++;
    assert (w_outs === e.outs) else begin
      errors++;
      $error("FAIL %s.outs: got %b expected %b", tag, w_outs, e.outs);
    end
  endtask

  // One clock step: expect state st with the current inputs.
  task automatic cyc(input string tag, input logic [3:0] st);
    exp_t e;
    e.st   = st;
    e.outs = model(st, opcode, funct, zero, mem_ready, to_cause);
    q.push_back(e);
    @(negedge clk);
    check_pop(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    exp_t e;
    e.st   = 4'd0;
    e.outs = '0;
    q.push_back(e);
    check_pop(tag);
  endtask

  initial begin
    opcode = 6'h0D;
    @(negedge clk);
    expect_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add
    opcode = 6'h00; funct = 6'h20;
    cyc("add", 0); cyc("add", 1); cyc("add", 2); cyc("add", 7);
    // sub, slt
    funct = 6'h22;
    cyc("sub", 0); cyc("sub", 1); cyc("sub", 2); cyc("sub", 7);
    funct = 6'h2A;
    cyc("slt", 0); cyc("slt", 1); cyc("slt", 2); cyc("slt", 7);
    // ori, addi, andi
    opcode = 6'h0D;
    cyc("ori", 0); cyc("ori", 1); cyc("ori", 3); cyc("ori", 8);
    opcode = 6'h08;
    cyc("addi", 0); cyc("addi", 1); cyc("addi", 3); cyc("addi", 8);
    opcode = 6'h0C;
    cyc("andi", 0); cyc("andi", 1); cyc("andi", 3); cyc("andi", 8);
    // lw with three wait cycles
    opcode = 6'h23;
    cyc("lw", 0); cyc("lw", 1); cyc("lw", 4);
    mem_ready = 1'b0;
    cyc("lw_wait", 5); cyc("lw_wait", 5); cyc("lw_wait", 5);
    mem_ready = 1'b1;
    cyc("lw", 5); cyc("lw", 9);
    // sw
    opcode = 6'h2B;
    cyc("sw", 0); cyc("sw", 1); cyc("sw", 4); cyc("sw", 6);
    // beq not taken / taken, j
    opcode = 6'h04; zero = 1'b0;
    cyc("beq_nt", 0); cyc("beq_nt", 1); cyc("beq_nt", 10);
    zero = 1'b1;
    cyc("beq_t", 0); cyc("beq_t", 1); cyc("beq_t", 10);
    zero = 1'b0;
    opcode = 6'h02;
    cyc("j", 0); cyc("j", 1); cyc("j", 11);
    // illegal opcode and illegal funct
    to_cause = 1'b0;
    opcode = 6'h3F;
    cyc("ill_op", 0); cyc("ill_op", 1); cyc("ill_op", 12);
    opcode = 6'h00; funct = 6'h21;
    cyc("ill_fn", 0); cyc("ill_fn", 1); cyc("ill_fn", 12);
    // fetch timeout: five wait cycles, then a bus error trap
    funct = 6'h20;
    mem_ready = 1'b0; to_cause = 1'b1;
    for (int i = 0; i < 5; i++) cyc("to_wait", 0);
    cyc("to_trap", 12);
    // ready on the limit cycle completes the access normally
    opcode = 6'h02;
    for (int i = 0; i < 4; i++) cyc("rdy_wait", 0);
    mem_ready = 1'b1;
    cyc("rdy_wins", 0); cyc("rdy_wins", 1); cyc("rdy_wins", 11);
    // asynchronous reset in the middle of a store
    opcode = 6'h2B;
    cyc("sw_rst", 0); cyc("sw_rst", 1); cyc("sw_rst", 4);
    mem_ready = 1'b0;
    cyc("sw_rst", 6);
    rst_n = 1'b0;
    #1;
    expect_reset("mid_rst");
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // three retiring instructions and one trap
    to_cause = 1'b0;
    opcode = 6'h00; funct = 6'h20;
    cyc("ret_add", 0); cyc("ret_add", 1); cyc("ret_add", 2); cyc("ret_add", 7);
    opcode = 6'h0D;
    cyc("ret_ori", 0); cyc("ret_ori", 1); cyc("ret_ori", 3); cyc("ret_ori", 8);
    opcode = 6'h02;
    cyc("ret_j", 0); cyc("ret_j", 1); cyc("ret_j", 11);
    opcode = 6'h3F;
    cyc("ret_ill", 0); cyc("ret_ill", 1); cyc("ret_ill", 12);
    opcode = 6'h00;
    cyc("after_trap", 0);
`ifdef MIPS_CTRL_RETIRE_CNT_EN
    checks++;
    assert (retired === 32'd3) else begin
      errors++;
      $error("FAIL retired: got %0d expected 3", retired);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
